commit_stage: RTL and testbench

- In-order retirement stage directly downstream of the issue scoreboard.
- Inspects the scoreboard head entry each cycle. Once its result has been written back, the block:
  - writes the architectural register file,
  - drains stores to the store buffer,
  - detects ebreak and halts the core,
  - counts retired instructions.
- Drives commit_valid back to the scoreboard to pop the head entry.

---
 rtl/OoO_pkg.sv | 19 +
 rtl/commit_stage_if.sv | 36 +++
 rtl/commit_stage.sv | 174 +++++++++++++++++
 tb/tb_commit_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/OoO_pkg.sv
// Shared types for the out-of-order core.
// decoder_t is the scoreboard entry layout; commit_stage reads the
// valid, result, pc, rd, rd_we, is_store and is_ebreak fields of the head entry.
package OoO_pkg;

    localparam int DecXlen     = 32;
    localparam int DecRegAddrW = 5;

    typedef struct packed {
        logic                   valid;
        logic [DecXlen-1:0]     pc;
        logic [DecXlen-1:0]     result;
        logic [DecRegAddrW-1:0] rd;
        logic                   rd_we;
        logic                   is_store;
        logic                   is_ebreak;
    } decoder_t;

endpackage

// File: rtl/commit_stage_if.sv
// Commit-stage bus: scoreboard head entry and pop, register-file write
// port and store-buffer release handshake.
// master = scoreboard / store-buffer side, slave = commit_stage.
interface commit_stage_if #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5
);
    OoO_pkg::decoder_t     commit_instr;
    logic                  commit_valid;
    logic                  rf_we;
    logic [RegAddrW-1:0]   rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  st_commit_valid;
    logic                  st_commit_ready;

    modport master (
        output commit_instr,
        output st_commit_ready,
        input  commit_valid,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  st_commit_valid
    );

    modport slave (
        input  commit_instr,
        input  st_commit_ready,
        output commit_valid,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output st_commit_valid
    );

endinterface

// File: rtl/commit_stage.sv
// In-order retirement stage below the issue scoreboard.
// Retires the head entry once written back: register-file write, store
// release to the store buffer, ebreak halt, retired-instruction count.
// Optional macro COMMIT_DIFFTEST_EN adds registered difftest ports.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | retire ALU/ebreak heads in the same cycle; stores go to STORE_REQ
// STORE_REQ | st_commit_valid held until the store buffer accepts; commit then
// HALTED    | ebreak retired; ignore everything until reset
module commit_stage #(
    parameter int XLEN     = 32,
    parameter int RegAddrW = 5,
    parameter int InstretW = 64
) (
    input  logic                clock,
    input  logic                reset,
    commit_stage_if.slave       cif,
    output logic                halt,
    output logic [XLEN-1:0]     halt_pc,
    output logic [XLEN-1:0]     halt_code,
    output logic [InstretW-1:0] minstret
`ifdef COMMIT_DIFFTEST_EN
    ,
    output logic                difftest_valid,
    output logic [XLEN-1:0]     difftest_pc,
    output logic                difftest_wen,
    output logic [RegAddrW-1:0] difftest_wdest,
    output logic [XLEN-1:0]     difftest_wdata
`endif
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_STORE_REQ = 2'd1,
        S_HALTED    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_commit_valid;
    logic                  w_rf_we;
    logic [RegAddrW-1:0]   w_rf_waddr;
    logic [XLEN-1:0]       w_rf_wdata;

    logic                  r_st_commit_valid;
    logic                  r_halt;
    logic [XLEN-1:0]       r_halt_pc;
    logic [XLEN-1:0]       r_halt_code;
    logic [InstretW-1:0]   r_minstret;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and same-cycle commit decision
    always_comb begin
        w_next_state   = r_state;
        w_commit_valid = 1'b0;
        case (r_state)
            S_RUN: begin
                if (cif.commit_instr.valid) begin
                    if (cif.commit_instr.is_ebreak) begin
                        w_commit_valid = 1'b1;
                        w_next_state   = S_HALTED;
                    end else if (cif.commit_instr.is_store) begin
                        w_next_state   = S_STORE_REQ;
                    end else begin
                        w_commit_valid = 1'b1;
                    end
                end
            end
            S_STORE_REQ: begin
                // The store pops only on the cycle the buffer takes the release.
                if (r_st_commit_valid && cif.st_commit_ready) begin
                    w_commit_valid = cif.commit_instr.valid;
                    w_next_state   = S_RUN;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Register-file write port; stores and x0 never write, data zeroed when idle
    always_comb begin
        w_rf_we    = w_commit_valid && cif.commit_instr.rd_we &&
                     (cif.commit_instr.rd != '0) && !cif.commit_instr.is_store;
        w_rf_waddr = w_rf_we ? cif.commit_instr.rd     : '0;
        w_rf_wdata = w_rf_we ? cif.commit_instr.result : '0;
    end

    // Store release request: high exactly while waiting in STORE_REQ
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_st_commit_valid <= 1'b0;
        end else begin
            r_st_commit_valid <= (w_next_state == S_STORE_REQ);
        end
    end

    // Sticky halt with the ebreak's pc and a0 value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halt      <= 1'b0;
            r_halt_pc   <= '0;
            r_halt_code <= '0;
        end else if ((r_state == S_RUN) && (w_next_state == S_HALTED)) begin
            r_halt      <= 1'b1;
            r_halt_pc   <= cif.commit_instr.pc;
            r_halt_code <= cif.commit_instr.result;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_minstret <= '0;
        end else if (w_commit_valid) begin
            r_minstret <= r_minstret + {{(InstretW-1){1'b0}}, 1'b1};
        end
    end

`ifdef COMMIT_DIFFTEST_EN
    logic                r_dt_valid;
    logic [XLEN-1:0]     r_dt_pc;
    logic                r_dt_wen;
    logic [RegAddrW-1:0] r_dt_wdest;
    logic [XLEN-1:0]     r_dt_wdata;

    // One-cycle-delayed copy of each retirement for the reference model
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dt_valid <= 1'b0;
            r_dt_pc    <= '0;
            r_dt_wen   <= 1'b0;
            r_dt_wdest <= '0;
            r_dt_wdata <= '0;
        end else begin
            r_dt_valid <= w_commit_valid;
            r_dt_pc    <= w_commit_valid ? cif.commit_instr.pc : '0;
            r_dt_wen   <= w_rf_we;
            r_dt_wdest <= w_rf_waddr;
            r_dt_wdata <= w_rf_wdata;
        end
    end

    assign difftest_valid = r_dt_valid;
    assign difftest_pc    = r_dt_pc;
    assign difftest_wen   = r_dt_wen;
    assign difftest_wdest = r_dt_wdest;
    assign difftest_wdata = r_dt_wdata;
`endif

    assign cif.commit_valid    = w_commit_valid;
    assign cif.rf_we           = w_rf_we;
    assign cif.rf_waddr        = w_rf_waddr;
    assign cif.rf_wdata        = w_rf_wdata;
    assign cif.st_commit_valid = r_st_commit_valid;
    assign halt                = r_halt;
    assign halt_pc             = r_halt_pc;
    assign halt_code           = r_halt_code;
    assign minstret            = r_minstret;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: a 64-bit-counter instance and a
// 4-bit-counter instance share the same head-entry stimulus.
module tb_commit_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt, halt4;
    logic [31:0] halt_pc, halt_code, halt_pc4, halt_code4;
    logic [63:0] minstret;
    logic [3:0]  minstret4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    commit_stage_if u_if ();
    commit_stage_if u_if4 ();

    assign u_if4.commit_instr    = u_if.commit_instr;
    assign u_if4.st_commit_ready = u_if.st_commit_ready;

    commit_stage #(.XLEN(32), .RegAddrW(5), .InstretW(64)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cif       (u_if.slave),
        .halt      (halt),
        .halt_pc   (halt_pc),
        .halt_code (halt_code),
        .minstret  (minstret)
    );

    commit_stage #(.XLEN(32), .RegAddrW(5), .InstretW(4)) u_dut4 (
        .clock     (clock),
        .reset     (reset),
        .cif       (u_if4.slave),
        .halt      (halt4),
        .halt_pc   (halt_pc4),
        .halt_code (halt_code4),
        .minstret  (minstret4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input logic v, input logic st, input logic eb,
                             input logic [4:0] rd, input logic we,
                             input logic [31:0] res, input logic [31:0] pc);
        u_if.commit_instr.valid     = v;
        u_if.commit_instr.is_store  = st;
        u_if.commit_instr.is_ebreak = eb;
        u_if.commit_instr.rd        = rd;
        u_if.commit_instr.rd_we     = we;
        u_if.commit_instr.result    = res;
        u_if.commit_instr.pc        = pc;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        u_if.st_commit_ready = 1'b0;
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cv", {63'd0, u_if.commit_valid}, 64'd0);
        chk("rst_stcv", {63'd0, u_if.st_commit_valid}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        reset = 1'b1;

        // Idle for 10 cycles after release
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_cv", {63'd0, u_if.commit_valid}, 64'd0);
            chk("idle_we", {63'd0, u_if.rf_we}, 64'd0);
            chk("idle_out", {u_if.rf_waddr, u_if.rf_wdata, u_if.st_commit_valid}, 64'd0);
            chk("idle_minstret", minstret, 64'd0);
        end

        // ALU write to x5
        next_cycle();
        set_entry(1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h8000_0000);
        @(negedge clock);
        chk("alu_cv", {63'd0, u_if.commit_valid}, 64'd1);
        chk("alu_we", {63'd0, u_if.rf_we}, 64'd1);
        chk("alu_waddr", {59'd0, u_if.rf_waddr}, 64'd5);
        chk("alu_wdata", {32'd0, u_if.rf_wdata}, 64'hDEADBEEF);
        next_cycle();
        chk("alu_minstret", minstret, 64'd1);

        // Write to x0 commits but does not write
        set_entry(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_1234, 32'h8000_0004);
        @(negedge clock);
        chk("x0_cv", {63'd0, u_if.commit_valid}, 64'd1);
        chk("x0_we", {63'd0, u_if.rf_we}, 64'd0);
        chk("x0_wdata", {32'd0, u_if.rf_wdata}, 64'd0);
        next_cycle();
        chk("x0_minstret", minstret, 64'd2);

        // Store; ready in the RUN cycle must be ignored
        set_entry(1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 32'h0000_0BAD, 32'h8000_0008);
        u_if.st_commit_ready = 1'b1;
        @(negedge clock);
        chk("st_run_cv", {63'd0, u_if.commit_valid}, 64'd0);
        chk("st_run_stcv", {63'd0, u_if.st_commit_valid}, 64'd0);
        next_cycle();
        u_if.st_commit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("st_wait_stcv", {63'd0, u_if.st_commit_valid}, 64'd1);
            chk("st_wait_cv", {63'd0, u_if.commit_valid}, 64'd0);
            next_cycle();
        end
        chk("st_wait_minstret", minstret, 64'd2);
        u_if.st_commit_ready = 1'b1;
        @(negedge clock);
        chk("st_hs_stcv", {63'd0, u_if.st_commit_valid}, 64'd1);
        chk("st_hs_cv", {63'd0, u_if.commit_valid}, 64'd1);
        chk("st_hs_we", {63'd0, u_if.rf_we}, 64'd0);
        next_cycle();
        u_if.st_commit_ready = 1'b0;
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        chk("st_done_stcv", {63'd0, u_if.st_commit_valid}, 64'd0);
        chk("st_minstret", minstret, 64'd3);
        @(negedge clock);
        chk("st_idle_cv", {63'd0, u_if.commit_valid}, 64'd0);

        // ebreak halts
        next_cycle();
        set_entry(1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h8000_0010);
        @(negedge clock);
        chk("eb_cv", {63'd0, u_if.commit_valid}, 64'd1);
        chk("eb_halt_pre", {63'd0, halt}, 64'd0);
        next_cycle();
        chk("eb_halt", {63'd0, halt}, 64'd1);
        chk("eb_halt_pc", {32'd0, halt_pc}, 64'h8000_0010);
        chk("eb_halt_code", {32'd0, halt_code}, 64'd0);
        chk("eb_minstret", minstret, 64'd4);
        set_entry(1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 32'h0000_0077, 32'h8000_0014);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("halted_cv", {63'd0, u_if.commit_valid}, 64'd0);
            chk("halted_we", {63'd0, u_if.rf_we}, 64'd0);
            next_cycle();
        end
        chk("halted_minstret", minstret, 64'd4);
        chk("halted_sticky", {63'd0, halt}, 64'd1);

        // Fresh reset, then 17 ALU commits: 4-bit counter wraps to 1
        reset = 1'b0;
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst2_halt", {63'd0, halt}, 64'd0);
        chk("rst2_minstret", minstret, 64'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        for (int i = 0; i < 17; i++) begin
            set_entry(1'b1, 1'b0, 1'b0, 5'(i % 31 + 1), 1'b1, 32'(i + 32'h100), 32'(32'h8000_0100 + 4 * i));
            @(negedge clock);
            chk("wrap_cv", {63'd0, u_if.commit_valid}, 64'd1);
            chk("wrap_wdata", {32'd0, u_if.rf_wdata}, 64'(i + 32'h100));
            next_cycle();
        end
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        chk("wrap_minstret64", minstret, 64'd17);
        chk("wrap_minstret4", {60'd0, minstret4}, 64'd1);

        // Reset during STORE_REQ drops the request immediately
        set_entry(1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 32'h0, 32'h8000_0200);
        next_cycle();
        chk("mid_stcv", {63'd0, u_if.st_commit_valid}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_stcv", {63'd0, u_if.st_commit_valid}, 64'd0);
        chk("mid_rst_cv", {63'd0, u_if.commit_valid}, 64'd0);
        chk("mid_rst_minstret", minstret, 64'd0);
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();
        // Back in RUN: ALU entry commits with ready low
        set_entry(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 32'h0000_0055, 32'h8000_0300);
        @(negedge clock);
        chk("post_cv", {63'd0, u_if.commit_valid}, 64'd1);
        chk("post_waddr", {59'd0, u_if.rf_waddr}, 64'd9);
        next_cycle();

        // ebreak with non-zero a0
        set_entry(1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0000_002A, 32'h8000_0304);
        next_cycle();
        set_entry(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        chk("eb2_halt_code", {32'd0, halt_code}, 64'h2A);
        chk("eb2_halt_pc", {32'd0, halt_pc}, 64'h8000_0304);
        chk("eb2_minstret", minstret, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
